// File: rtl/riscv_pkg.sv
// Shared RV32 core types: data width, default boot address and the
// fetch-path entry and state encodings.
package riscv_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   typedef enum logic {
      FETCH = 1'b0,
      FULL  = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instr} pairs in a register array.
// A flush empties it in one cycle and overrides push and pop.
module fetch_fifo
   import riscv_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  fetch_entry_t             wdata,
   output fetch_entry_t             rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   fetch_entry_t   mem [DEPTH];
   logic [AW-1:0]  head;
   logic [AW-1:0]  tail;

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[tail] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            tail <= tail + AW'(1);
         end
         if (pop) begin
            head <= head + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   assign rdata = mem[head];
   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: sequential PC generation, prefetch buffering
// of variable-latency ROM words, and EX redirect handling.
//
// Handshakes: decode takes the head entry in any cycle where f_valid && f_ready
// are both high, except in a redirect cycle, where that transfer is void. The
// ROM word is taken in any cycle where i_data_valid is high, no redirect is
// present and there is room (not FULL, or a pop in the same cycle).
module fetch_unit
   import riscv_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [31:0] i_address,
   input  logic [31:0] i_data_read,
   input  logic        i_data_valid,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        f_valid,
   input  logic        f_ready,
   output logic [31:0] f_instr,
   output logic [31:0] f_pc,
   output logic        f_misaligned,
   output logic        state_dbg
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t   state;
   logic [31:0]    fpc;
   logic           push;
   logic           pop;
   logic           fifo_full;
   logic           fifo_empty;
   logic [CW-1:0]  count;
   fetch_entry_t   wdata;
   fetch_entry_t   rdata;

   assign f_valid = !fifo_empty;
   assign pop     = f_valid && f_ready && !redirect_valid;
   assign push    = i_data_valid && !redirect_valid && ((state == FETCH) || pop);

   assign wdata.pc    = fpc;
   assign wdata.instr = i_data_read;

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .flush   (redirect_valid),
      .wdata   (wdata),
      .rdata   (rdata),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (count)
   );

   // FULL tracks count == DEPTH exactly; a pop paired with a push keeps it FULL.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= FETCH;
         fpc          <= RESET_PC;
         f_misaligned <= 1'b0;
      end else if (redirect_valid) begin
         state        <= FETCH;
         fpc          <= {redirect_pc[31:2], 2'b00};
         f_misaligned <= (redirect_pc[1:0] != 2'b00);
      end else begin
         f_misaligned <= 1'b0;
         if (push) begin
            fpc <= fpc + 32'd4;
         end
         case (state)
            FETCH: if (push && !pop && count == CW'(DEPTH - 1)) state <= FULL;
            FULL:  if (pop && !push) state <= FETCH;
            default: state <= FETCH;
         endcase
      end
   end

   assign i_address = fpc;
   assign f_instr   = f_valid ? rdata.instr : 32'h0;
   assign f_pc      = f_valid ? rdata.pc : 32'h0;
   assign state_dbg = (state == FULL);

   logic unused_full;
   assign unused_full = fifo_full;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model of the prefetch buffer
// fed by a driver, with an independent monitor comparing the decode side.
module tb_fetch_unit;
   import riscv_pkg::*;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] i_address;
   logic [31:0] i_data_read = '0;
   logic        i_data_valid = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        f_valid;
   logic        f_ready = 1'b0;
   logic [31:0] f_instr;
   logic [31:0] f_pc;
   logic        f_misaligned;
   logic        state_dbg;

   always #5 clk = ~clk;

   fetch_unit #(
      .DEPTH    (DEPTH),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .i_address      (i_address),
      .i_data_read    (i_data_read),
      .i_data_valid   (i_data_valid),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .f_valid        (f_valid),
      .f_ready        (f_ready),
      .f_instr        (f_instr),
      .f_pc           (f_pc),
      .f_misaligned   (f_misaligned),
      .state_dbg      (state_dbg)
   );

   // ---------------- scoreboard state ----------------
   logic [63:0] exp_q[$];      // {pc, instr} entries the DUT must hold
   logic [31:0] exp_fpc = 32'h0;
   logic        exp_mis = 1'b0;
   int          checks = 0;
   int          errors = 0;
   bit          done = 1'b0;

   bit          pend_rv = 1'b0;
   bit          pend_push = 1'b0;
   logic [31:0] pend_rpc = '0;
   logic [31:0] pend_pc = '0;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF ^ (a * 32'd3);
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
      end
   endtask

   // Apply the effect of last cycle's inputs to the model (after the edge).
   task automatic commit();
      if (pend_rv) begin
         exp_q.delete();
         exp_fpc = {pend_rpc[31:2], 2'b00};
         exp_mis = (pend_rpc[1:0] != 2'b00);
      end else begin
         exp_mis = 1'b0;
         if (pend_push) begin
            exp_q.push_back({pend_pc, rom_word(pend_pc)});
            exp_fpc = pend_pc + 32'd4;
         end
      end
      pend_rv   = 1'b0;
      pend_push = 1'b0;
   endtask

   // ---------------- driver ----------------
   task automatic cycle(input bit dv, input bit rdy, input bit rv, input logic [31:0] rpc);
      bit pop;
      @(negedge clk);
      #1;
      commit();
      i_data_valid   = dv;
      f_ready        = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      i_data_read    = dv ? rom_word(exp_fpc) : $urandom();
      pop       = (exp_q.size() != 0) && rdy && !rv;
      pend_rv   = rv;
      pend_rpc  = rpc;
      pend_pc   = exp_fpc;
      pend_push = dv && !rv && ((exp_q.size() < DEPTH) || pop);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      commit();
      reset_n        = 1'b0;
      i_data_valid   = 1'b1;
      f_ready        = 1'b0;
      redirect_valid = 1'b0;
      i_data_read    = 32'hDEAD_BEEF;
      #1;
      chk("rst_i_address", i_address, 32'h0);
      chk("rst_f_valid", f_valid, 1'b0);
      chk("rst_f_instr", f_instr, 32'h0);
      chk("rst_f_pc", f_pc, 32'h0);
      chk("rst_f_misaligned", f_misaligned, 1'b0);
      chk("rst_state", state_dbg, 1'b0);
      exp_q.delete();
      exp_fpc   = 32'h0;
      exp_mis   = 1'b0;
      pend_rv   = 1'b0;
      pend_push = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_hold_i_address", i_address, 32'h0);
      chk("rst_hold_f_valid", f_valid, 1'b0);
      i_data_valid = 1'b0;
      reset_n      = 1'b1;
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      #2;
      if (reset_n && !done) begin
         chk("i_address", i_address, exp_fpc);
         chk("f_valid", f_valid, exp_q.size() != 0);
         chk("f_misaligned", f_misaligned, exp_mis);
         chk("state_full", state_dbg, exp_q.size() == DEPTH);
         if (exp_q.size() != 0) begin
            chk("f_pc", f_pc, exp_q[0][63:32]);
            chk("f_instr", f_instr, exp_q[0][31:0]);
            if (f_ready && !redirect_valid) begin
               void'(exp_q.pop_front());
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      do_reset();

      // Stream from reset with decode always ready.
      repeat (8) cycle(1'b1, 1'b1, 1'b0, 32'h0);

      // Backpressure from PC 0: fills, freezes at 0x10, then drains.
      cycle(1'b0, 1'b0, 1'b1, 32'h0);
      repeat (6) cycle(1'b1, 1'b0, 1'b0, 32'h0);
      repeat (8) cycle(1'b1, 1'b1, 1'b0, 32'h0);

      // Redirect while holding 0x0..0x8, with a same-cycle ROM word.
      cycle(1'b0, 1'b0, 1'b1, 32'h0);
      repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0);
      cycle(1'b1, 1'b1, 1'b1, 32'h200);
      repeat (4) cycle(1'b1, 1'b1, 1'b0, 32'h0);

      // Misaligned redirect target.
      cycle(1'b1, 1'b1, 1'b1, 32'h103);
      repeat (4) cycle(1'b1, 1'b1, 1'b0, 32'h0);

      // ROM valid every third cycle, decode sometimes stalled.
      for (int i = 0; i < 30; i++) begin
         cycle(i % 3 == 0, $urandom_range(0, 3) != 0, 1'b0, 32'h0);
      end

      // Address wrap past the top of memory.
      cycle(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
      repeat (4) cycle(1'b1, 1'b1, 1'b0, 32'h0);

      // Randomized mix of all inputs.
      for (int i = 0; i < 500; i++) begin
         logic [31:0] rpc;
         rpc = $urandom_range(0, 1) ? $urandom() : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
         cycle($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
               $urandom_range(0, 15) == 0, rpc);
      end

      // Fill to FULL, then reset in the middle of operation.
      cycle(1'b0, 1'b0, 1'b1, 32'h40);
      repeat (6) cycle(1'b1, 1'b0, 1'b0, 32'h0);
      do_reset();
      repeat (6) cycle(1'b1, 1'b1, 1'b0, 32'h0);

      @(negedge clk);
      #1;
      done = 1'b1;
      #10;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
